// File: rtl/sb_pkg.sv
// sb_pkg: shared sideband packet width, inter-packet gap length and serializer state type
package sb_pkg;
  localparam int SB_PKT_W = 64;
  localparam int SB_GAP_UI = 32;
  typedef enum logic [1:0] {IDLE, LOADED, SHIFT, GAP} sb_ser_state_t;
endpackage

// File: rtl/sb_ui_counter.sv
// sb_ui_counter: load/decrement UI counter (i_clk, i_rst_n, i_load+i_load_val wins over i_dec) with o_tc high at zero
module sb_ui_counter #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt <= '0;
    else if (i_load) cnt <= i_load_val;
    else if (i_dec && cnt != '0) cnt <= cnt - W'(1);
  assign o_tc = cnt == '0;
endmodule

// File: rtl/sb_tx_serializer.sv
// sb_tx_serializer: FWFT packet capture on i_read_enable, LSB-first shift-out after i_clk_en (o_txdata/o_txclk_en), o_ser_done on last bit, o_packet_finished over the gap
module sb_tx_serializer
  import sb_pkg::*;
#(
  parameter int DATA_W = SB_PKT_W,
  parameter int GAP_UI = SB_GAP_UI
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_read_enable,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clk_en,
  output logic              o_read_enable_sampled,
  output logic              o_txdata,
  output logic              o_txclk_en,
  output logic              o_ser_done,
  output logic              o_packet_finished
);
  localparam int BW = $clog2(DATA_W);
  localparam int GW = $clog2(GAP_UI + 1);
  sb_ser_state_t state, state_d;
  logic [DATA_W-1:0] sreg, sreg_d;
  logic txdata_d, txclk_en_d, ser_done_d, pkt_fin_d, sampled_d;
  logic bit_load, bit_tc, gap_load, gap_tc;
  sb_ui_counter #(.W(BW)) u_bit_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(bit_load), .i_load_val(BW'(DATA_W - 1)),
    .i_dec(state == SHIFT), .o_tc(bit_tc)
  );
  sb_ui_counter #(.W(GW)) u_gap_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(gap_load), .i_load_val(GW'(GAP_UI)),
    .i_dec(state == GAP), .o_tc(gap_tc)
  );
  always_comb begin
    state_d = state;
    sreg_d = sreg;
    txdata_d = 1'b0;
    txclk_en_d = 1'b0;
    ser_done_d = 1'b0;
    pkt_fin_d = 1'b0;
    sampled_d = 1'b0;
    bit_load = 1'b0;
    gap_load = 1'b0;
    case (state)
      IDLE: if (i_read_enable) begin
        sreg_d = i_data;
        sampled_d = 1'b1;
        state_d = LOADED;
      end
      LOADED: if (i_clk_en) begin
        bit_load = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        txdata_d = sreg[0];
        sreg_d = sreg >> 1;
        txclk_en_d = 1'b1;
        ser_done_d = bit_tc;
        gap_load = bit_tc;
        state_d = bit_tc ? GAP : SHIFT;
      end
      GAP: begin
        pkt_fin_d = !gap_tc;
        state_d = gap_tc ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      sreg <= '0;
      o_read_enable_sampled <= 1'b0;
      o_txdata <= 1'b0;
      o_txclk_en <= 1'b0;
      o_ser_done <= 1'b0;
      o_packet_finished <= 1'b0;
    end else begin
      state <= state_d;
      sreg <= sreg_d;
      o_read_enable_sampled <= sampled_d;
      o_txdata <= txdata_d;
      o_txclk_en <= txclk_en_d;
      o_ser_done <= ser_done_d;
      o_packet_finished <= pkt_fin_d;
    end
endmodule

// File: tb/tb_sb_tx_serializer.sv
// tb_sb_tx_serializer: directed/randomized packets checked against a per-UI timeline model of the serializer
module tb_sb_tx_serializer;
  logic clk = 1'b0;
  logic rst_n, re, clk_en;
  logic [63:0] din;
  logic sampled, txdata, txclk_en, ser_done, pkt_fin;
  int tests = 0;
  int fails = 0;
  sb_tx_serializer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_read_enable(re), .i_data(din), .i_clk_en(clk_en),
    .o_read_enable_sampled(sampled), .o_txdata(txdata), .o_txclk_en(txclk_en),
    .o_ser_done(ser_done), .o_packet_finished(pkt_fin)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_outs(input string ph, input int k, input logic s, input logic td, input logic ce, input logic sd, input logic pf);
    chk($sformatf("%s sampled k=%0d", ph, k), sampled, s);
    chk($sformatf("%s txdata k=%0d", ph, k), txdata, td);
    chk($sformatf("%s txclk_en k=%0d", ph, k), txclk_en, ce);
    chk($sformatf("%s ser_done k=%0d", ph, k), ser_done, sd);
    chk($sformatf("%s pkt_fin k=%0d", ph, k), pkt_fin, pf);
  endtask
  // k counts edges after the capture edge: bits occupy k=2..65, gap flag k=66..97, idle again at k=98
  task automatic run_packet(input string ph, input logic [63:0] d, input int hold, input bit wild,
                            input int next_k, input logic [63:0] nd, input int abort_k);
    int ce_cnt = 0;
    int sd_cnt = 0;
    re = 1'b1;
    din = d;
    tick;
    chk_outs(ph, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clk_en = 1'b1;
    re = hold > 1;
    din = {$urandom, $urandom};
    for (int k = 1; k <= 98; k++) begin
      tick;
      begin
        logic e_ce;
        e_ce = k >= 2 && k <= 65;
        chk_outs(ph, k, 1'b0, e_ce ? d[k-2] : 1'b0, e_ce, k == 65, k >= 66 && k <= 97);
      end
      ce_cnt += int'(txclk_en);
      sd_cnt += int'(ser_done);
      if (k == abort_k) begin
        #2 rst_n = 1'b0;
        re = 1'b0;
        clk_en = 1'b0;
        #1 chk_outs({ph, " async-rst"}, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        rst_n = 1'b1;
        tick;
        tick;
        chk_outs({ph, " post-rst"}, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      clk_en = wild ? 1'($urandom) : 1'b0;
      re = k + 1 < hold;
      if (!re) din = {$urandom, $urandom};
      if (next_k > 0 && k >= next_k) begin
        re = 1'b1;
        din = nd;
      end
    end
    chk({ph, " txclk_en count"}, 64'(ce_cnt), 64'd64);
    chk({ph, " ser_done count"}, 64'(sd_cnt), 64'd1);
    clk_en = 1'b0;
  endtask
  initial begin
    logic [63:0] r;
    rst_n = 1'b0;
    re = 1'b0;
    clk_en = 1'b0;
    din = '0;
    #3 chk_outs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk_outs("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_packet("single", 64'hA5A5_0000_FFFF_1234, 1, 1'b0, 0, '0, 0);
    run_packet("hold3", {$urandom, $urandom}, 3, 1'b0, 0, '0, 0);
    run_packet("b2b-first", 64'h1, 1, 1'b0, 98, 64'h8000_0000_0000_0000, 0);
    r = {$urandom, $urandom};
    run_packet("b2b-second", 64'h8000_0000_0000_0000, 1, 1'b0, 80, r, 0);
    run_packet("mid-gap-re", r, 1, 1'b0, 0, '0, 0);
    run_packet("abort", {$urandom, $urandom}, 1, 1'b0, 0, '0, 22);
    run_packet("after-abort", {$urandom, $urandom}, 1, 1'b0, 0, '0, 0);
    for (int i = 0; i < 3; i++) run_packet($sformatf("wild-clk-en%0d", i), {$urandom, $urandom}, 1, 1'b1, 0, '0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
